hs_table_updater: RTL and testbench
===================================

# hs_table_updater

Sequencer that inserts a finished game's score into the three-entry high-score RAM (`hsRAM`) and sits directly upstream of it, driving its `cs`/`we`/`addr`/`data_in` and `DONE_WR` pins. On a game-over `start` pulse it reads the three stored scores, finds the new score's rank, and rewrites the table in descending order. It then pulses `done_wr` so the RAM flushes to `scores.txt`. If the score does not place, the table is left untouched and `done_wr` is not pulsed.

## Interface
- No parameters. Table depth is fixed at 3; score width is fixed at 32.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  game-over pulse; sampled only in IDLE.
- `score`  in  32  final score, unsigned; latched on the accepted `start`.
- `ram_q`  in  32  read data from the RAM (`data_out`), combinational from `ram_addr`.
- `ram_cs`  out  1  RAM chip select.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  2  RAM address, 0..2; entry 0 is the highest score.
- `ram_d`  out  32  RAM write data.
- `done_wr`  out  1  one-cycle pulse after the table was rewritten.
- `done`  out  1  one-cycle pulse at the end of every accepted request.
- `busy`  out  1  high in every state other than IDLE.
- `rank`  out  2  result of the last request: 0..2 is the placement, 3 means not placed; held until the next request.

## Operation
- Internal registers:
  - `new_s[31:0]`: latched score.
  - `hs0..hs2[31:0]`: table copy.
  - `pos[1:0]`: insertion position.
- State sequence: IDLE → RD0 → RD1 → RD2 → CMP → WR0 → WR1 → WR2 → FIN → IDLE.
- IDLE: when `start`=1, latch `score` into `new_s` and go to RD0. Otherwise stay.
- RDk (k=0..2): drive `ram_cs`=1, `ram_we`=0, `ram_addr`=k. At the end of the cycle, capture `ram_q` into `hsk`.
- CMP: compute `pos` as the smallest k with `new_s` > `hsk`, using an unsigned strict compare; `pos`=3 if none.
  - Ties rank below the existing entry.
  - Register `rank` ← `pos`.
  - If `pos`=3, go to FIN; otherwise go to WR0.
- WRk: drive `ram_cs`=1, `ram_we`=1, `ram_addr`=k. `ram_d` is:
  - `hsk` if k < `pos`;
  - `new_s` if k = `pos`;
  - `hs(k-1)` if k > `pos`.
  - The old `hs2` is discarded.
- FIN: `done`=1 for one cycle. `done_wr`=1 only if the WR states were executed this request. Then go to IDLE.
- RAM controls are decoded from the registered state.
  - Outside RD/WR states: `ram_cs`=0, `ram_we`=0, `ram_addr`=0, `ram_d`=0.
  - `ram_we` is never high while `ram_cs` is low.
- `start` is ignored in every state other than IDLE; there is no queueing.
- `busy` is a pure decode of state ≠ IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE;
  - `ram_cs`, `ram_we`, `ram_addr`, `ram_d`, `done`, `done_wr`, `busy` all 0;
  - `rank`=3;
  - `new_s` and `hs0..hs2` = 0.
- Reset released mid-sequence restarts in IDLE. Partial writes already committed stay in RAM; no `done`/`done_wr` is produced for the aborted request.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
  - RD0 occupies the cycle after E0; RD1, RD2 and CMP follow, one cycle each.
  - Placed score: WR0..WR2 follow CMP, then FIN. FIN is the 8th cycle after E0 (RD0 is the 1st). `busy` is high for 8 cycles.
  - Not placed: FIN is the 5th cycle after E0. `busy` is high for 5 cycles.
- `rank` updates on the edge that leaves CMP and is valid from the following cycle.
- `start` held high continuously: a new request is accepted on the edge that leaves FIN → IDLE? No — only on an edge sampled while in IDLE. Back-to-back requests therefore have at least one IDLE cycle between FIN and the next RD0.

## Test plan
- RAM preloaded {300,200,100}, `score`=250 → RD0..RD2 read 300,200,100; `rank`=1; writes 300,250,200 to addr 0,1,2; `done` and `done_wr` pulse together in cycle 8 after E0.
- Same preload, `score`=50 → `rank`=3; `ram_we` never asserted; `done`=1 in cycle 5 with `done_wr`=0; RAM unchanged.
- Same preload, `score`=200 (tie) → `rank`=2; RAM becomes {300,200,200}.
- RAM {0,0,0}, `score`=0xFFFFFFFF → `rank`=0; RAM becomes {0xFFFFFFFF,0,0}. Then `score`=0 → `rank`=3.
- `start` pulsed again during WR1 → ignored; exactly one `done` pulse; a following `start` in IDLE is processed normally.
- `rst_n` asserted during WR1 → outputs go to reset values immediately; RAM addr 0 already rewritten, addr 1..2 untouched; no `done_wr`; `rank`=3.

Source files
------------

// File: rtl/hs_table_updater.sv
`default_nettype none
// ============================================================================
// Module   : hs_table_updater
// Purpose  : Inserts a finished game's score into the three-entry high-score
//            RAM. It reads the stored scores, ranks the new score with an
//            unsigned strict compare (ties rank below), and rewrites the
//            table in descending order. It then pulses done_wr so the RAM
//            flushes its contents.
// Revision : 1.0  initial release
// ============================================================================
module hs_table_updater (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] score,
  input  logic [31:0] ram_q,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [1:0]  ram_addr,
  output logic [31:0] ram_d,
  output logic        done_wr,
  output logic        done,
  output logic        busy,
  output logic [1:0]  rank
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD0  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_CMP  = 4'd4,
    S_WR0  = 4'd5,
    S_WR1  = 4'd6,
    S_WR2  = 4'd7,
    S_FIN  = 4'd8
  } state_t;

  localparam logic [1:0] c_NOT_PLACED = 2'd3;

  state_t      r_state;
  logic [31:0] r_new_s;
  logic [31:0] r_hs0;
  logic [31:0] r_hs1;
  logic [31:0] r_hs2;
  // Insertion position of the current request; doubles as the reported rank.
  logic [1:0]  r_rank;
  logic [1:0]  w_pos;

  // First table entry the new score strictly beats; equal scores stay below.
  always_comb begin
    if (r_new_s > r_hs0)      w_pos = 2'd0;
    else if (r_new_s > r_hs1) w_pos = 2'd1;
    else if (r_new_s > r_hs2) w_pos = 2'd2;
    else                      w_pos = c_NOT_PLACED;
  end

  // Sequencer: latch request, read the table, rank, rewrite, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_new_s <= 32'd0;
      r_hs0   <= 32'd0;
      r_hs1   <= 32'd0;
      r_hs2   <= 32'd0;
      r_rank  <= c_NOT_PLACED;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_new_s <= score;
            r_state <= S_RD0;
          end
        end
        S_RD0: begin
          r_hs0   <= ram_q;
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_hs1   <= ram_q;
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_hs2   <= ram_q;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_rank  <= w_pos;
          r_state <= (w_pos == c_NOT_PLACED) ? S_FIN : S_WR0;
        end
        S_WR0:   r_state <= S_WR1;
        S_WR1:   r_state <= S_WR2;
        S_WR2:   r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM port decode from the registered state; entries above the insertion
  // point are kept, the new score goes in at it, lower entries shift down.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = 2'd0;
    ram_d    = 32'd0;
    case (r_state)
      S_RD0: begin
        ram_cs   = 1'b1;
        ram_addr = 2'd0;
      end
      S_RD1: begin
        ram_cs   = 1'b1;
        ram_addr = 2'd1;
      end
      S_RD2: begin
        ram_cs   = 1'b1;
        ram_addr = 2'd2;
      end
      S_WR0: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 2'd0;
        ram_d    = (r_rank == 2'd0) ? r_new_s : r_hs0;
      end
      S_WR1: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 2'd1;
        if (r_rank > 2'd1)       ram_d = r_hs1;
        else if (r_rank == 2'd1) ram_d = r_new_s;
        else                     ram_d = r_hs0;
      end
      S_WR2: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 2'd2;
        if (r_rank == 2'd2) ram_d = r_new_s;
        else                ram_d = r_hs1;
      end
      default: begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = 2'd0;
        ram_d    = 32'd0;
      end
    endcase
  end

  // Status decode; done_wr only when the write phase ran (score placed).
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_FIN);
    done_wr = (r_state == S_FIN) && (r_rank != c_NOT_PLACED);
    rank    = r_rank;
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_table_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_table_updater
// Purpose  : Self-checking bench for hs_table_updater with a behavioural
//            three-entry RAM and a queue of expected write transactions.
// Revision : 1.0  initial release
// ============================================================================
module tb_hs_table_updater;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] score;
  logic [31:0] ram_q;
  logic        ram_cs;
  logic        ram_we;
  logic [1:0]  ram_addr;
  logic [31:0] ram_d;
  logic        done_wr;
  logic        done;
  logic        busy;
  logic [1:0]  rank;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         q_exp[$];
  logic [31:0] mem [3];
  int          n_asserts;
  int          n_fail;

  hs_table_updater dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .score    (score),
    .ram_q    (ram_q),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .done_wr  (done_wr),
    .done     (done),
    .busy     (busy),
    .rank     (rank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, write on rising edge.
  assign ram_q = (ram_addr < 2'd3) ? mem[ram_addr] : 32'd0;
  always @(posedge clk) begin
    if (ram_cs && ram_we && ram_addr < 2'd3) mem[ram_addr] <= ram_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    mem[0] = a;
    mem[1] = b;
    mem[2] = c;
  endtask

  task automatic chk_mem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    chk("mem0", mem[0], a);
    chk("mem1", mem[1], b);
    chk("mem2", mem[2], c);
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q_exp.push_back(e);
  endtask

  // One request; expected writes must be queued beforehand. pulse_at names
  // a cycle (1 = RD0) in which start is raised again, 0 for none.
  task automatic run_req(input logic [31:0] s, input logic [1:0] exp_rank, input int pulse_at);
    int  n;
    wr_t e;
    n = (exp_rank == 2'd3) ? 5 : 8;
    @(negedge clk);
    start = 1'b1;
    score = s;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      chk("busy", busy, 1);
      chk("done", done, (c == n));
      chk("done_wr", done_wr, (c == n) && (exp_rank != 2'd3));
      if (c <= 3) begin
        chk("rd_cs", ram_cs, 1);
        chk("rd_we", ram_we, 0);
        chk("rd_addr", ram_addr, c - 1);
      end else begin
        chk("we", ram_we, (exp_rank != 2'd3) && (c >= 5) && (c <= 7));
      end
      if (ram_we) begin
        chk("wr_cs", ram_cs, 1);
        if (q_exp.size() == 0) begin
          chk("wr_unexpected", ram_we, 0);
        end else begin
          e = q_exp.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_d, e.d);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("rank", rank, exp_rank);
    chk("wr_pending", q_exp.size(), 0);
  endtask

  initial begin
    wr_t e;
    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    score     = 32'd0;
    preload(32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_cs", ram_cs, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_d", ram_d, 0);
    chk("rst_done", done, 0);
    chk("rst_done_wr", done_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rank", rank, 3);
    rst_n = 1'b1;

    // Middle placement
    preload(32'd300, 32'd200, 32'd100);
    push(2'd0, 32'd300); push(2'd1, 32'd250); push(2'd2, 32'd200);
    run_req(32'd250, 2'd1, 0);
    chk_mem(32'd300, 32'd250, 32'd200);

    // Not placed: table untouched
    preload(32'd300, 32'd200, 32'd100);
    run_req(32'd50, 2'd3, 0);
    chk_mem(32'd300, 32'd200, 32'd100);

    // Tie ranks below the existing entry
    push(2'd0, 32'd300); push(2'd1, 32'd200); push(2'd2, 32'd200);
    run_req(32'd200, 2'd2, 0);
    chk_mem(32'd300, 32'd200, 32'd200);

    // Unsigned extremes
    preload(32'd0, 32'd0, 32'd0);
    push(2'd0, 32'hFFFF_FFFF); push(2'd1, 32'd0); push(2'd2, 32'd0);
    run_req(32'hFFFF_FFFF, 2'd0, 0);
    chk_mem(32'hFFFF_FFFF, 32'd0, 32'd0);
    run_req(32'd0, 2'd3, 0);
    chk_mem(32'hFFFF_FFFF, 32'd0, 32'd0);

    // Start raised during WR1 is ignored, then a normal request follows
    preload(32'd300, 32'd200, 32'd100);
    push(2'd0, 32'd300); push(2'd1, 32'd250); push(2'd2, 32'd200);
    run_req(32'd250, 2'd1, 6);
    repeat (2) begin
      @(negedge clk);
      chk("ignored_busy", busy, 0);
      chk("ignored_done", done, 0);
    end
    push(2'd0, 32'd300); push(2'd1, 32'd260); push(2'd2, 32'd250);
    run_req(32'd260, 2'd1, 0);
    chk_mem(32'd300, 32'd260, 32'd250);

    // Reset during WR1: WR0 committed, rest untouched
    preload(32'd300, 32'd200, 32'd100);
    push(2'd0, 32'd400);
    @(negedge clk);
    start = 1'b1;
    score = 32'd400;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_wr0_we", ram_we, 1);
    if (ram_we && q_exp.size() != 0) begin
      e = q_exp.pop_front();
      chk("abort_wr0_addr", ram_addr, e.a);
      chk("abort_wr0_data", ram_d, e.d);
    end
    @(negedge clk);
    chk("abort_wr1_addr", ram_addr, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", ram_cs, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_d", ram_d, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done_wr", done_wr, 0);
    chk("abort_rank", rank, 3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_done_wr", done_wr, 0);
      chk("post_abort_busy", busy, 0);
    end
    chk_mem(32'd400, 32'd200, 32'd100);
    chk("abort_pending", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
